// File: rtl/dsm_pkg.sv
// Shared constants and types for the stereo delta-sigma audio DAC.
package dsm_pkg;

    localparam int PCM_W      = 16;
    localparam int ACC_W      = 16;
    localparam int FIFO_DEPTH = 2;

    // XOR with midscale converts two's complement to offset binary
    localparam logic [PCM_W-1:0] MIDSCALE  = 16'h8000;
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;
    // Taps x^16 + x^14 + x^13 + x^11 as bit positions 15, 13, 12, 10
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [PCM_W-1:0] left;
        logic [PCM_W-1:0] right;
    } frame_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {state[14:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dsm_channel.sv
// First-order delta-sigma modulator for one audio channel; the carry out of the
// accumulator is the registered bitstream.
module dsm_channel
    import dsm_pkg::*;
(
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             tick,
    input  logic [PCM_W-1:0] x,
    input  logic [2:0]       dither,
    output logic             bitstream
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum = {1'b0, acc} + {1'b0, x ^ MIDSCALE} + {{(ACC_W - 2){1'b0}}, dither};
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            acc       <= '0;
            bitstream <= 1'b0;
        end else if (tick) begin
            acc       <= sum[ACC_W-1:0];
            bitstream <= sum[ACC_W];
        end
    end

endmodule

// File: rtl/dsm_audio_dac.sv
// Stereo 1-bit delta-sigma DAC: 2-entry PCM frame FIFO, tick dividers and two modulators.
// Define DSM_DITHER_EN to add LFSR dither to both modulator sums.
module dsm_audio_dac
    import dsm_pkg::*;
#(
    parameter int unsigned MOD_DIV    = 1,
    parameter int unsigned SAMPLE_DIV = 1562
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PCM_W-1:0] in_left,
    input  logic [PCM_W-1:0] in_right,
    input  logic             mute,
    output logic             sound_l,
    output logic             sound_r,
    output logic             underrun,
    output logic             sample_tick
);

    logic [7:0]  mod_cnt;
    logic [15:0] smp_cnt;
    logic        tick;
    logic        frame_wrap;

    frame_t      fifo_mem [FIFO_DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  fifo_count;
    logic        push;
    logic        pop;
    logic        fifo_empty;

    frame_t           cur_frame;
    logic [PCM_W-1:0] x_l;
    logic [PCM_W-1:0] x_r;
    logic [2:0]       dither_l;
    logic [2:0]       dither_r;

    assign tick       = (mod_cnt == 8'(MOD_DIV - 1));
    assign frame_wrap = tick && (smp_cnt == 16'(SAMPLE_DIV - 1));
    assign fifo_empty = (fifo_count == 2'd0);
    assign in_ready   = (fifo_count < 2'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    // A pop decision uses the pre-edge count, so a same-edge push into an empty FIFO still underruns
    assign pop        = frame_wrap && !fifo_empty;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            mod_cnt     <= '0;
            smp_cnt     <= '0;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            mod_cnt     <= tick ? 8'd0 : mod_cnt + 8'd1;
            sample_tick <= frame_wrap;
            underrun    <= frame_wrap && fifo_empty;
            if (tick) begin
                smp_cnt <= frame_wrap ? 16'd0 : smp_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= '0;
            cur_frame  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr    <= ~rd_ptr;
                cur_frame <= fifo_mem[rd_ptr];
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{left: in_left, right: in_right};
        end
    end

`ifdef DSM_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            lfsr <= LFSR_SEED;
        end else if (tick) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign dither_l = lfsr[2:0];
    assign dither_r = lfsr[5:3];
`else
    assign dither_l = 3'd0;
    assign dither_r = 3'd0;
`endif

    // Mute swaps the input to midscale so the stream keeps a 50% duty without a DC step
    assign x_l = mute ? '0 : cur_frame.left;
    assign x_r = mute ? '0 : cur_frame.right;

    dsm_channel u_chan_l (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .tick      (tick),
        .x         (x_l),
        .dither    (dither_l),
        .bitstream (sound_l)
    );

    dsm_channel u_chan_r (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .tick      (tick),
        .x         (x_r),
        .dither    (dither_r),
        .bitstream (sound_r)
    );

endmodule
